instruction_queue: RTL
======================

# instruction_queue

Parametrised instruction buffer between the memory fetch path and the decoder, the next generation of the single-register instruction latch. Fetched words, with their debug sideband (address-increment, debug op, debug mode), are pushed into a DEPTH-entry FIFO. An EXECUTE strobe transfers the head entry into the decoder-facing output registers, split into GROUPX and INSTRUCTION fields. FLUSH discards all queued words on a control-flow change, and an empty-queue bypass path preserves single-cycle latency when the queue is drained.

## Interface
- DATA_WIDTH, 16, fetched word width
- GROUP_WIDTH, 2, width of the group field in the top bits of the word
- DEBUG_OP_WIDTH, 3, width of the debug op sideband
- DEPTH, 4, queue entries; power of two, ≥2
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- FLUSH  in  1  discard queue contents and invalidate output
- DIN  in  DATA_WIDTH  fetched instruction word
- DIN_VALID  in  1  DIN and sideband valid this cycle
- DIN_READY  out  1  queue accepts a push; equals !FULL
- DEBUG_ADDR_INC  in  1  sideband, captured with DIN
- DEBUG_OP  in  DEBUG_OP_WIDTH  sideband, captured with DIN
- DEBUG_MODE  in  1  sideband, captured with DIN
- EXECUTE  in  1  decoder requests next instruction
- INSTRUCTION  out  DATA_WIDTH-GROUP_WIDTH  low bits of the issued word
- GROUPX  out  GROUP_WIDTH  top bits of the issued word
- DEBUG_ADDR_INC_I, DEBUG_OP_I, DEBUG_MODE_I  out  1 / DEBUG_OP_WIDTH / 1  sideband of the issued word
- INSTR_VALID  out  1  output registers hold a word issued by the most recent EXECUTE
- EMPTY  out  1  COUNT == 0
- FULL  out  1  COUNT == DEPTH
- COUNT  out  $clog2(DEPTH)+1  number of queued entries

## Operation
- Reset (RESET=1 at an edge): all outputs 0, COUNT 0, read and write pointers 0, EMPTY 1, FULL 0, DIN_READY 1. Reset overrides every other input.
- Priority at an edge: RESET > FLUSH > EXECUTE/push.
- FLUSH:
  - COUNT and both pointers go to 0 and INSTR_VALID goes to 0.
  - INSTRUCTION, GROUPX and the sideband outputs hold their values.
  - A concurrent push or EXECUTE is ignored.
- Push: DIN_VALID && DIN_READY writes {DIN, sideband} at the write pointer. The write pointer then increments modulo DEPTH.
- EXECUTE with COUNT>0:
  - The head entry loads into the output registers: GROUPX = word[DATA_WIDTH-1 -: GROUP_WIDTH], INSTRUCTION = remaining low bits.
  - INSTR_VALID goes to 1 and the read pointer increments modulo DEPTH.
- EXECUTE with COUNT==0 and a push in the same cycle (bypass):
  - DIN and sideband load directly into the output registers, and INSTR_VALID goes to 1.
  - The queue is unchanged (COUNT stays 0).
- EXECUTE with COUNT==0 and no push: output data holds and INSTR_VALID goes to 0.
- No EXECUTE: output registers and INSTR_VALID hold.
- COUNT update: +1 for a non-bypassed push, −1 for a pop, unchanged for push and pop in the same cycle.
- FULL: DIN_READY=0, so a push is refused even when EXECUTE pops in the same cycle. This keeps the ready path combinationally independent of EXECUTE.
- Pointers wrap naturally. COUNT carries the extra bit that distinguishes full from empty.

## Timing
- All outputs are registered except DIN_READY, EMPTY and FULL, which decode directly from COUNT (registered state, no input paths).
- Push-to-issue latency:
  - Queued path: word pushed at edge N is issuable by EXECUTE sampled at edge N+1, and outputs update after edge N+1.
  - Bypass path: outputs update after the same edge that samples DIN.
- Issue-to-issue: EXECUTE may be high on consecutive cycles, one word per edge while COUNT>0.
- After FLUSH at edge N, pushes are accepted from edge N+1.

## Structure
- Shared package: DATA_WIDTH and GROUP_WIDTH defaults, DEBUG_OP_WIDTH, and a packed entry typedef {debug_mode, debug_op, debug_addr_inc, word}.
- Sub-module instr_queue_mem holds the entry array:
  - One write port and one asynchronous read port.
  - No reset on the array contents.
- Top level holds the pointers, COUNT, bypass mux and output registers.

## Test plan
- Reset mid-fill: push 0x1234 and 0x5678, assert RESET one edge -> COUNT=0, EMPTY=1, INSTRUCTION=0, GROUPX=0, INSTR_VALID=0.
- Fill and drain, DEPTH=4:
  - Push 0xC001, 0x4002, 0x8003, 0x0004 -> FULL=1, DIN_READY=0, and a fifth push of 0xFFFF is refused.
  - Then 4 EXECUTEs -> GROUPX/INSTRUCTION = 3/0x0001, 1/0x0002, 2/0x0003, 0/0x0004; EMPTY=1.
- Bypass: with the queue empty, push 0xBEEF with EXECUTE the same cycle and DEBUG_OP=5, DEBUG_MODE=1 -> next cycle INSTRUCTION=0x3EEF, GROUPX=2, DEBUG_OP_I=5, DEBUG_MODE_I=1, COUNT=0.
- Simultaneous push and pop at COUNT=2 -> COUNT stays 2 and order is preserved across pointer wrap (run 10 cycles).
- FLUSH with push and EXECUTE asserted at COUNT=3 -> COUNT=0, INSTR_VALID=0, output data unchanged, and the pushed word is lost.
- EXECUTE on empty with no push -> INSTR_VALID=0, INSTRUCTION holds its previous value.

Source files
------------

// File: rtl/instruction_queue_pkg.sv
// Shared definitions for the instruction queue.
//   IQ_DATA_WIDTH / IQ_GROUP_WIDTH / IQ_DEBUG_OP_WIDTH : default widths
//   iq_entry_t : packed queue entry at the default widths
//                {debug_mode, debug_op, debug_addr_inc, word}
package instruction_queue_pkg;

  localparam int IQ_DATA_WIDTH     = 16;
  localparam int IQ_GROUP_WIDTH    = 2;
  localparam int IQ_DEBUG_OP_WIDTH = 3;

  typedef struct packed {
    logic                         debug_mode;
    logic [IQ_DEBUG_OP_WIDTH-1:0] debug_op;
    logic                         debug_addr_inc;
    logic [IQ_DATA_WIDTH-1:0]     word;
  } iq_entry_t;

endpackage

// File: rtl/instr_queue_mem.sv
// Entry storage for the instruction queue.
//   CLK      : clock
//   wr_en    : write wr_data at wr_addr on the rising edge
//   wr_addr  : write index
//   wr_data  : entry to store
//   rd_addr  : asynchronous read index
//   rd_data  : entry at rd_addr
// Contents are deliberately not reset; validity is tracked by the
// pointers and COUNT in the parent.
module instr_queue_mem
  import instruction_queue_pkg::*;
#(
  parameter int WIDTH = $bits(iq_entry_t),
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_queue.sv
// Instruction buffer between the fetch path and the decoder.
//   CLK, RESET (sync, active-high), FLUSH
//   DIN / DIN_VALID / DIN_READY        : fetch-side push interface
//   DEBUG_ADDR_INC / DEBUG_OP / DEBUG_MODE : sideband captured with DIN
//   EXECUTE                            : decoder requests next word
//   INSTRUCTION / GROUPX / DEBUG_*_I   : registered issued word
//   INSTR_VALID                        : output holds word from last EXECUTE
//   EMPTY / FULL / COUNT               : occupancy
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int DATA_WIDTH     = IQ_DATA_WIDTH,
  parameter int GROUP_WIDTH    = IQ_GROUP_WIDTH,
  parameter int DEBUG_OP_WIDTH = IQ_DEBUG_OP_WIDTH,
  parameter int DEPTH          = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              FLUSH,
  input  logic [DATA_WIDTH-1:0]             DIN,
  input  logic                              DIN_VALID,
  output logic                              DIN_READY,
  input  logic                              DEBUG_ADDR_INC,
  input  logic [DEBUG_OP_WIDTH-1:0]         DEBUG_OP,
  input  logic                              DEBUG_MODE,
  input  logic                              EXECUTE,
  output logic [DATA_WIDTH-GROUP_WIDTH-1:0] INSTRUCTION,
  output logic [GROUP_WIDTH-1:0]            GROUPX,
  output logic                              DEBUG_ADDR_INC_I,
  output logic [DEBUG_OP_WIDTH-1:0]         DEBUG_OP_I,
  output logic                              DEBUG_MODE_I,
  output logic                              INSTR_VALID,
  output logic                              EMPTY,
  output logic                              FULL,
  output logic [$clog2(DEPTH):0]            COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic                      debug_mode;
    logic [DEBUG_OP_WIDTH-1:0] debug_op;
    logic                      debug_addr_inc;
    logic [DATA_WIDTH-1:0]     word;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          instr_valid_q;
  entry_t        out_q;
  entry_t        din_entry, head_entry, issue_entry;
  logic          push, pop, bypass, wr_en;

  assign EMPTY     = (count_q == '0);
  assign FULL      = (count_q == DEPTH_C);
  assign DIN_READY = !FULL;

  assign din_entry = '{debug_mode: DEBUG_MODE, debug_op: DEBUG_OP,
                       debug_addr_inc: DEBUG_ADDR_INC, word: DIN};

  assign push   = DIN_VALID && DIN_READY;
  assign pop    = EXECUTE && !EMPTY;
  assign bypass = EXECUTE && EMPTY && push;
  // A bypassed word never enters the array; flush/reset also drop the push.
  assign wr_en  = push && !bypass && !FLUSH && !RESET;

  assign issue_entry = pop ? head_entry : din_entry;

  instr_queue_mem #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (din_entry),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      out_q         <= '0;
    end else if (FLUSH) begin
      // Output data is kept so the decoder still sees the last word.
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);

      if (pop || bypass) begin
        out_q         <= issue_entry;
        instr_valid_q <= 1'b1;
      end else if (EXECUTE) begin
        instr_valid_q <= 1'b0;
      end

      if (wr_en && !pop)      count_q <= count_q + CW'(1);
      else if (!wr_en && pop) count_q <= count_q - CW'(1);
    end
  end

  assign INSTRUCTION      = out_q.word[DATA_WIDTH-GROUP_WIDTH-1:0];
  assign GROUPX           = out_q.word[DATA_WIDTH-1 -: GROUP_WIDTH];
  assign DEBUG_ADDR_INC_I = out_q.debug_addr_inc;
  assign DEBUG_OP_I       = out_q.debug_op;
  assign DEBUG_MODE_I     = out_q.debug_mode;
  assign INSTR_VALID      = instr_valid_q;
  assign COUNT            = count_q;

endmodule
